multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OPW, 6, opcode width.
REQ-002 SHALL have parameter FNW, 6, funct width.
REQ-003 SHALL have parameter ASW, 4, ALU select width.
REQ-004 SHALL have parameter MEM_TIMEOUT, 16, max wait cycles for mem_ready (>=1).
REQ-005 SHALL have parameter CNTW, 32, retired-counter width.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with the ports listed below.
REQ-007 SHALL have port clk  in  1  rising-edge clock.
REQ-008 SHALL have port reset  in  1  synchronous active-high reset.
REQ-009 SHALL have port opcode, funct  in  OPW/FNW  fields from external instruction register.
REQ-010 SHALL have port zero  in  1  ALU zero flag.
REQ-011 SHALL have port mem_ready  in  1  unified memory access complete.
REQ-012 SHALL have port mem_read, mem_write, iord  out  1 each  memory strobes; address select (0 = PC, 1 = ALU).
REQ-013 SHALL have port ir_write, pc_write  out  1 each  IR load; PC update.
REQ-014 SHALL have port pc_select  out  2  00 increment, 01 branch, 10 jump.
REQ-015 SHALL have port reg_write, reg_dst, mem_to_reg, alu_src  out  1 each  regfile/ALU mux controls.
REQ-016 SHALL have port alu_sel  out  ASW  ALU operation: ADD 0, SUB 1, MUL 2, DIV 3, AND 4, OR 5.
REQ-017 SHALL have port trap, trap_cause  out  1, 1  sticky halt; cause (0 = illegal opcode, 1 = memory timeout).
REQ-018 SHALL have port retired  out  CNTW  count of completed instructions.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, TRAP; outputs are a combinational function of state, latched decode and zero; unlisted outputs are 0.
REQ-020 FETCH SHALL drive mem_read=1, iord=0; on mem_ready it SHALL pulse ir_write=1 and pc_write=1 with pc_select=00, then go to DECODE; otherwise it holds.
REQ-021 DECODE SHALL last one cycle and latch opcode/funct into internal registers; supported opcodes 000000 R, 100011 lw, 101011 sw, 000100 beq, 000010 j go to EXEC, any other opcode goes to TRAP with cause 0.
REQ-022 R-type funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 011000 MUL, 011010 DIV, other = ADD.
REQ-023 EXEC, R-type: alu_src=0, alu_sel from funct, next state WB.
REQ-024 EXEC, lw/sw: alu_src=1, ADD; lw goes to MEM_RD, sw goes to MEM_WR.
REQ-025 EXEC, beq: SUB, pc_select=01, pc_write=zero, next state FETCH.
REQ-026 EXEC, j: pc_select=10, pc_write=1, next state FETCH.
REQ-027 MEM_RD SHALL drive mem_read=1, iord=1 and go to WB on mem_ready.
REQ-028 MEM_WR SHALL drive mem_write=1, iord=1 and go to FETCH on mem_ready.
REQ-029 WB SHALL drive reg_write=1 for one cycle (reg_dst=1 for R-type; mem_to_reg=1 for lw), then go to FETCH.
REQ-030 Latency with mem_ready=1 on the first wait cycle SHALL be: R 4 cycles, lw 5, sw 4, beq 3, j 3.
REQ-031 A wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR; if mem_ready is still 0 after MEM_TIMEOUT cycles in one wait, next state is TRAP with cause 1.
REQ-032 If mem_ready arrives in the same cycle as the timeout, mem_ready SHALL win.
REQ-033 TRAP SHALL hold trap=1, keep trap_cause stable, drive all strobes 0, and leave only on reset.
REQ-034 retired SHALL increment by 1 on leaving WB, on the EXEC->FETCH transition (beq/j), and on MEM_WR completion; it wraps modulo 2^CNTW.

Reset
REQ-035 While reset=1 at a clock edge, next state SHALL be FETCH, and trap, trap_cause, the latched decode, the wait counter and retired SHALL be 0.
REQ-036 While reset is high, all outputs SHALL be forced to 0, including mid-wait, where the access is abandoned.
REQ-037 The first FETCH strobe SHALL appear in the first cycle after reset deasserts.

Configuration
REQ-038 Macro PERF_CNT_EN defined: retired counter SHALL be implemented per REQ-034.
REQ-039 Macro PERF_CNT_EN undefined: retired port SHALL remain present, tied to 0, with no counter flops.

Structure
REQ-040 Package ctrl_pkg SHALL hold opcode/funct constants, ALU select encodings, pc_select encodings, the state enum and the trap cause codes.
REQ-041 Sub-module ctrl_decode SHALL be a combinational map from opcode/funct to instruction class, alu_sel and legal flag.

Verification
REQ-042 Reset, then R ADD (funct 100000) with mem_ready always 1 -> states FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1 in cycle 4; retired=1.
REQ-043 lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; then WB with mem_to_reg=1.
REQ-044 beq with zero=0, then beq with zero=1 -> pc_write 0, then 1 with pc_select=01; 3 cycles each.
REQ-045 Opcode 111111 -> TRAP after DECODE with trap=1, trap_cause=0; stays in TRAP until reset.
REQ-046 MEM_TIMEOUT=4 with mem_ready never asserted in FETCH -> TRAP with cause 1; also mem_ready on the 4th cycle -> DECODE, no trap.
REQ-047 Reset asserted mid MEM_WR wait -> mem_write=0 that cycle; FETCH follows; retired=0 (PERF_CNT_EN defined).

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants, state enum and instruction classes for the multicycle controller.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic TRAP_ILLEGAL = 1'b0;
  localparam logic TRAP_TIMEOUT = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LW, C_SW, C_BEQ, C_J, C_ILL
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class, ALU select and legality.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int FNW = 6,
  parameter int ASW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  output iclass_t        iclass,
  output logic [ASW-1:0] alu_sel,
  output logic           legal
);

  always_comb begin
    iclass  = C_ILL;
    alu_sel = '0;
    legal   = 1'b0;
    case (opcode)
      OPW'(OP_RTYPE): begin
        iclass = C_R;
        legal  = 1'b1;
        // Unrecognised funct codes fall back to ADD.
        case (funct)
          FNW'(FN_SUB): alu_sel = ASW'(ALU_SUB);
          FNW'(FN_AND): alu_sel = ASW'(ALU_AND);
          FNW'(FN_OR):  alu_sel = ASW'(ALU_OR);
          FNW'(FN_MUL): alu_sel = ASW'(ALU_MUL);
          FNW'(FN_DIV): alu_sel = ASW'(ALU_DIV);
          default:      alu_sel = ASW'(ALU_ADD);
        endcase
      end
      OPW'(OP_LW): begin
        iclass  = C_LW;
        legal   = 1'b1;
        alu_sel = ASW'(ALU_ADD);
      end
      OPW'(OP_SW): begin
        iclass  = C_SW;
        legal   = 1'b1;
        alu_sel = ASW'(ALU_ADD);
      end
      OPW'(OP_BEQ): begin
        iclass  = C_BEQ;
        legal   = 1'b1;
        alu_sel = ASW'(ALU_SUB);
      end
      OPW'(OP_J): begin
        iclass = C_J;
        legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait timeout and sticky trap.
// Define PERF_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
// mem_ready handshake: a memory access is requested for as long as mem_read/mem_write is high
// and completes in the first cycle where mem_ready is sampled high alongside the strobe.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int FNW         = 6,
  parameter int ASW         = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNTW        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic [FNW-1:0]  funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_read,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_write,
  output logic            pc_write,
  output logic [1:0]      pc_select,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src,
  output logic [ASW-1:0]  alu_sel,
  output logic            trap,
  output logic            trap_cause,
  output logic [CNTW-1:0] retired,
  output state_t          dbg_state
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic [FNW-1:0] fn_q;
  logic           cause_q;
  logic [WCW-1:0] wcnt;

  iclass_t        cls;
  logic [ASW-1:0] sel;
  logic           legal;
  logic           timeout;

  // One decoder: live fields while in DECODE, latched fields everywhere else.
  ctrl_decode #(.OPW(OPW), .FNW(FNW), .ASW(ASW)) u_decode (
    .opcode  ((state == S_DECODE) ? opcode : op_q),
    .funct   ((state == S_DECODE) ? funct  : fn_q),
    .iclass  (cls),
    .alu_sel (sel),
    .legal   (legal)
  );

  assign timeout = (wcnt == WCW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      cause_q <= 1'b0;
      wcnt    <= '0;
    end else begin
      wcnt <= '0;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state   <= S_TRAP;
            cause_q <= TRAP_TIMEOUT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          fn_q <= funct;
          if (legal) begin
            state <= S_EXEC;
          end else begin
            state   <= S_TRAP;
            cause_q <= TRAP_ILLEGAL;
          end
        end
        S_EXEC: begin
          case (cls)
            C_R:     state <= S_WB;
            C_LW:    state <= S_MEM_RD;
            C_SW:    state <= S_MEM_WR;
            default: state <= S_FETCH;
          endcase
        end
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            state <= (state == S_MEM_RD) ? S_WB : S_FETCH;
          end else if (timeout) begin
            state   <= S_TRAP;
            cause_q <= TRAP_TIMEOUT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_select  = PC_INC;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_sel    = '0;
    trap       = 1'b0;
    trap_cause = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_sel = sel;
          alu_src = (cls == C_LW) || (cls == C_SW);
          if (cls == C_BEQ) begin
            pc_select = PC_BRANCH;
            pc_write  = zero;
          end else if (cls == C_J) begin
            pc_select = PC_JUMP;
            pc_write  = 1'b1;
          end
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (cls == C_R);
          mem_to_reg = (cls == C_LW);
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = reset ? S_FETCH : state;

`ifdef PERF_CNT_EN
  logic            retire;
  logic [CNTW-1:0] ret_q;

  assign retire = (state == S_WB)
               || ((state == S_EXEC) && ((cls == C_BEQ) || (cls == C_J)))
               || ((state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) ret_q <= '0;
    else if (retire) ret_q <= ret_q + 1'b1;
  end

  assign retired = reset ? '0 : ret_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle scripts built from the
// instruction semantics, directed corner cases, then randomized instruction streams.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int OPW  = 6;
  localparam int FNW  = 6;
  localparam int ASW  = 4;
  localparam int TMO  = 4;
  localparam int CNTW = 32;

  typedef struct packed {
    logic       mr, mw, io, irw, pcw;
    logic [1:0] pcs;
    logic       rw, rd, m2r, as;
    logic [3:0] sel;
    logic       tr, tc;
  } ovec_t;

  logic            clk = 1'b0;
  logic            reset, zero, mem_ready;
  logic [OPW-1:0]  opcode;
  logic [FNW-1:0]  funct;
  logic            mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0]      pc_select;
  logic            reg_write, reg_dst, mem_to_reg, alu_src;
  logic [ASW-1:0]  alu_sel;
  logic            trap, trap_cause;
  logic [CNTW-1:0] retired;
  state_t          dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [CNTW-1:0] exp_retired = '0;

  ovec_t  exp_q[$];
  state_t st_q[$];
  logic   rdy_q[$];

  multicycle_control #(
    .OPW(OPW), .FNW(FNW), .ASW(ASW), .MEM_TIMEOUT(TMO), .CNTW(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_select(pc_select),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_sel(alu_sel), .trap(trap), .trap_cause(trap_cause),
    .retired(retired), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic ovec_t observed();
    ovec_t v;
    v = {mem_read, mem_write, iord, ir_write, pc_write, pc_select,
         reg_write, reg_dst, mem_to_reg, alu_src, alu_sel, trap, trap_cause};
    return v;
  endfunction

  function automatic logic [CNTW-1:0] exp_ret();
`ifdef PERF_CNT_EN
    return exp_retired;
`else
    return '0;
`endif
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 4'd1;
      6'b011000: return 4'd2;
      6'b011010: return 4'd3;
      6'b100100: return 4'd4;
      6'b100101: return 4'd5;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // driver: one clock cycle, outputs checked at the falling edge
  task automatic step(input logic rdy, input logic rst, input ovec_t e, input state_t es,
                      input bit chk_st, input string tag);
    ovec_t o;
    reset     = rst;
    mem_ready = rdy;
    @(negedge clk);
    o = observed();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, o, e);
    end
    if (chk_st) begin
      checks++;
      assert (dbg_state === es) else begin
        failures++;
        $error("FAIL %s state observed=%s expected=%s", tag, dbg_state.name(), es.name());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_retired(input string tag);
    checks++;
    assert (retired === exp_ret()) else begin
      failures++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp_ret());
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, ovec_t'('0), S_FETCH, 1'b0, "reset");
    exp_retired = '0;
    chk_retired("reset_retired");
  endtask

  // scoreboard: expected per-cycle script
  task automatic push(input logic rdy, input ovec_t v, input state_t s);
    rdy_q.push_back(rdy);
    exp_q.push_back(v);
    st_q.push_back(s);
  endtask

  task automatic play(input string tag);
    while (exp_q.size() > 0)
      step(rdy_q.pop_front(), 1'b0, exp_q.pop_front(), st_q.pop_front(), 1'b1, tag);
  endtask

  task automatic push_fetch(input int d, input bit complete);
    ovec_t v;
    v = '0; v.mr = 1'b1;
    for (int i = 0; i < d; i++) push(1'b0, v, S_FETCH);
    if (complete) begin
      v.irw = 1'b1; v.pcw = 1'b1; v.pcs = 2'b00;
      push(1'b1, v, S_FETCH);
    end
  endtask

  task automatic push_mem(input bit rd, input int d, input bit complete);
    ovec_t v;
    v = '0; v.io = 1'b1;
    if (rd) v.mr = 1'b1; else v.mw = 1'b1;
    for (int i = 0; i < d; i++) push(1'b0, v, rd ? S_MEM_RD : S_MEM_WR);
    if (complete) push(1'b1, v, rd ? S_MEM_RD : S_MEM_WR);
  endtask

  task automatic push_trap(input logic cause, input int n);
    ovec_t v;
    v = '0; v.tr = 1'b1; v.tc = cause;
    for (int i = 0; i < n; i++) push(rnd(), v, S_TRAP);
  endtask

  task automatic push_exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    ovec_t v;
    v = '0;
    push(rnd(), v, S_DECODE);
    case (op)
      6'b000000: v.sel = alu_of(fn);
      6'b100011, 6'b101011: v.as = 1'b1;
      6'b000100: begin v.sel = 4'd1; v.pcs = 2'b01; v.pcw = z; end
      6'b000010: begin v.pcs = 2'b10; v.pcw = 1'b1; end
      default: ;
    endcase
    push(rnd(), v, S_EXEC);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int df, input int dm, input string tag);
    ovec_t v;
    opcode = op; funct = fn; zero = z;
    push_fetch(df, 1'b1);
    push_exec(op, fn, z);
    v = '0; v.rw = 1'b1;
    if (op == 6'b000000) begin
      v.rd = 1'b1;
      push(rnd(), v, S_WB);
    end else if (op == 6'b100011) begin
      push_mem(1'b1, dm, 1'b1);
      v.m2r = 1'b1;
      push(rnd(), v, S_WB);
    end else if (op == 6'b101011) begin
      push_mem(1'b0, dm, 1'b1);
    end
    play(tag);
    exp_retired = exp_retired + 1'b1;
    chk_retired(tag);
  endtask

  initial begin
    logic [5:0] ops [5];
    logic [5:0] fns [7];
    logic [5:0] op, fn;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b011000, 6'b011010, 6'b111111};
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, "r_add");
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, "lw_wait3");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, "beq_z0");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, "beq_z1");
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 2, "sw_wait2");
    run_instr(6'b000000, 6'b100010, 1'b0, TMO - 1, 0, "fetch_ready_last");
    run_instr(6'b101011, 6'b000000, 1'b0, 0, TMO - 1, "memwr_ready_last");

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 4)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      run_instr(op, fn, rnd(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), "rand");
    end

    // fetch never acknowledged: trap with timeout cause
    push_fetch(TMO, 1'b0);
    push_trap(1'b1, 4);
    play("fetch_timeout");
    chk_retired("fetch_timeout_retired");
    do_reset(1);

    // illegal opcode: trap right after decode
    opcode = 6'b111111; funct = '0;
    push_fetch(0, 1'b1);
    push(rnd(), ovec_t'('0), S_DECODE);
    push_trap(1'b0, 5);
    play("illegal_op");
    do_reset(1);

    // load whose data phase never completes
    opcode = 6'b100011;
    push_fetch(1, 1'b1);
    push_exec(6'b100011, 6'b000000, 1'b0);
    push_mem(1'b1, TMO, 1'b0);
    push_trap(1'b1, 3);
    play("memrd_timeout");
    do_reset(1);

    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, "j_after_reset");

    // reset in the middle of a store wait abandons the access
    opcode = 6'b101011;
    push_fetch(0, 1'b1);
    push_exec(6'b101011, 6'b000000, 1'b0);
    push_mem(1'b0, 2, 1'b0);
    play("sw_before_reset");
    step(1'b0, 1'b1, ovec_t'('0), S_FETCH, 1'b0, "reset_mid_memwr");
    exp_retired = '0;
    chk_retired("reset_mid_memwr_retired");
    run_instr(6'b000010, 6'b000000, 1'b0, 1, 0, "first_fetch_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
